// File: rtl/sequential_divider.sv
// sequential_divider: iterative unsigned restoring divider, one quotient bit
// per enabled clock. Computes q = n / d and r = n % d behind a start/busy/done
// handshake; results hold until the next completion.
module sequential_divider #(
   parameter int WIDTH_N = 16,
   parameter int WIDTH_D = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               start,
   input  logic [WIDTH_N-1:0] n,
   input  logic [WIDTH_D-1:0] d,
   output logic               busy,
   output logic               done,
   output logic [WIDTH_N-1:0] q,
   output logic [WIDTH_D-1:0] r,
   output logic               div_by_zero
);

   // Counter must hold WIDTH_N-1; keep at least one bit for WIDTH_N == 1.
   localparam int CNT_W = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH_N-1:0] dvd_q,   dvd_d;    // dividend shifting out, quotient shifting in
   logic [WIDTH_D-1:0] dvs_q,   dvs_d;    // latched divisor
   logic [WIDTH_D:0]   rem_q,   rem_d;    // partial remainder, one guard bit
   logic [CNT_W-1:0]   cnt_q,   cnt_d;    // steps remaining after the current one
   logic [WIDTH_N-1:0] q_q,     q_d;
   logic [WIDTH_D-1:0] r_q,     r_d;
   logic               dbz_q,   dbz_d;

   // One restoring step. The shifted remainder is kept one bit wider than the
   // partial remainder so the sign of the trial difference is exact: the
   // shifted value is always below 2*d, so it cannot overflow either way.
   logic [WIDTH_D+1:0] shifted;
   logic [WIDTH_D+1:0] trial;
   logic               qbit;
   logic [WIDTH_D:0]   rem_step;
   logic [WIDTH_N-1:0] dvd_step;

   // Combinational trial subtraction for the CALC step.
   always_comb begin
      shifted  = {rem_q, dvd_q[WIDTH_N-1]};
      trial    = shifted - {2'b00, dvs_q};
      qbit     = ~trial[WIDTH_D+1];
      rem_step = qbit ? trial[WIDTH_D:0] : shifted[WIDTH_D:0];
      dvd_step = (dvd_q << 1) | WIDTH_N'(qbit);
   end

   // Next-state and datapath update; with en low every register holds.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  dvd_d = n;
                  dvs_d = d;
                  rem_d = '0;
                  if (d != '0) begin
                     cnt_d   = CNT_W'(WIDTH_N - 1);
                     state_d = CALC;
                  end else begin
                     // Division by zero skips the iteration entirely.
                     q_d     = '1;
                     r_d     = '0;
                     dbz_d   = 1'b1;
                     state_d = DONE;
                  end
               end
            end
            CALC: begin
               dvd_d = dvd_step;
               rem_d = rem_step;
               if (cnt_q == '0) begin
                  // Last step: publish the result on the edge entering DONE.
                  q_d     = dvd_step;
                  r_d     = rem_step[WIDTH_D-1:0];
                  dbz_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; reset overrides enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == DONE);
   assign q           = q_q;
   assign r           = r_q;
   assign div_by_zero = dbz_q;

endmodule
